// File: rtl/pix_align_delay.sv
// -----------------------------------------------------------------------------
// pix_align_delay
//   Runtime-programmable alignment delay for pixel-pair data and the ZBT write
//   address that travels with it. Every cycle one {valid, addr, data} sample
//   is written into a circular buffer of MAX_DELAY entries. The registered
//   outputs replay that sample d_cur cycles later. A change of the requested
//   delay drops everything in flight and refills the pipe (cfg_busy high).
//
// Ports
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_delay_sel   requested delay in cycles (0 -> 1, > MAX_DELAY -> MAX_DELAY)
//   i_in_valid    sample present this cycle
//   i_in_data     pixel-pair data
//   i_in_addr     write address paired with i_in_data
//   o_out_valid   delayed sample valid
//   o_out_data    delayed data (holds while o_out_valid is low)
//   o_out_addr    delayed address (holds while o_out_valid is low)
//   o_cfg_busy    high while refilling after a delay change
// -----------------------------------------------------------------------------
module pix_align_delay #(
  parameter int DATA_W    = 36,
  parameter int ADDR_W    = 19,
  parameter int MAX_DELAY = 128,
  parameter int DSEL_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DSEL_W-1:0] i_delay_sel,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [ADDR_W-1:0] i_in_addr,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_cfg_busy
);

  localparam int PTR_W  = $clog2(MAX_DELAY);
  localparam int DW     = PTR_W + 1;          // wide enough to hold MAX_DELAY
  localparam int WORD_W = ADDR_W + DATA_W;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Saturate the requested delay into the legal range 1..MAX_DELAY.
  function automatic logic [DW-1:0] f_clamp(input logic [DSEL_W-1:0] sel);
    logic [31:0] v;
    v = 32'(sel);
    if (v == 32'd0) begin
      f_clamp = DW'(1);
    end else if (v > 32'(MAX_DELAY)) begin
      f_clamp = DW'(MAX_DELAY);
    end else begin
      f_clamp = DW'(v);
    end
  endfunction

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [MAX_DELAY-1:0] r_vld;
  logic [WORD_W-1:0] r_mem [MAX_DELAY];
  logic [DW-1:0]     r_d_cur;
  logic [DW-1:0]     r_fill_cnt;
  logic [0:0]        r_state;

  logic [DW-1:0]     w_d_req;
  logic              w_change;
  logic [0:0]        w_state_nxt;
  logic [DW-1:0]     w_fill_nxt;
  logic [PTR_W-1:0]  w_rd_idx;
  logic              w_rd_vld;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_out_vld_nxt;

  assign w_d_req  = f_clamp(i_delay_sel);
  assign w_change = (w_d_req != r_d_cur);

  // Slot holding the sample captured d_cur-1 edges ago; modulo wrap is implicit.
  assign w_rd_idx = r_wr_ptr - r_d_cur[PTR_W-1:0] + PTR_W'(1);

  // Next-state / refill counter: any delay change (re)starts a flush.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    if (w_change) begin
      w_state_nxt = ST_FLUSH;
      w_fill_nxt  = w_d_req;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          w_fill_nxt  = r_fill_cnt;
        end
        ST_FLUSH: begin
          if (r_fill_cnt <= DW'(1)) begin
            w_state_nxt = ST_RUN;
            w_fill_nxt  = DW'(0);
          end else begin
            w_state_nxt = ST_FLUSH;
            w_fill_nxt  = r_fill_cnt - DW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_fill_nxt  = DW'(0);
        end
      endcase
    end
  end

  // Read side; a delay of 1 has not been written yet, so bypass the input.
  always_comb begin
    if (r_d_cur == DW'(1)) begin
      w_rd_vld  = i_in_valid;
      w_rd_word = {i_in_addr, i_in_data};
    end else begin
      w_rd_vld  = r_vld[w_rd_idx];
      w_rd_word = r_mem[w_rd_idx];
    end
  end

  // Gate with the state being entered so the first refilled sample is not lost.
  assign w_out_vld_nxt = w_rd_vld && (w_state_nxt == ST_RUN);

  // Data/address storage: written every cycle, no reset needed.
  always_ff @(posedge i_clk) begin
    r_mem[r_wr_ptr] <= {i_in_addr, i_in_data};
  end

  // Valid tags: cleared on reset and on every delay change (including the
  // sample captured on the change edge, which belongs to the old delay).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
    end else if (w_change) begin
      r_vld <= '0;
    end else begin
      r_vld[r_wr_ptr] <= i_in_valid;
    end
  end

  // Write pointer, delay register and FSM state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_d_cur    <= w_d_req;
      r_fill_cnt <= DW'(0);
      r_state    <= ST_RUN;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      r_fill_cnt <= w_fill_nxt;
      r_state    <= w_state_nxt;
      if (w_change) begin
        r_d_cur <= w_d_req;
      end else begin
        r_d_cur <= r_d_cur;
      end
    end
  end

  // Registered outputs; data/address hold while no valid sample emerges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_addr  <= '0;
      o_cfg_busy  <= 1'b0;
    end else begin
      o_out_valid <= w_out_vld_nxt;
      o_cfg_busy  <= (w_state_nxt == ST_FLUSH);
      if (w_out_vld_nxt) begin
        o_out_addr <= w_rd_word[WORD_W-1:DATA_W];
        o_out_data <= w_rd_word[DATA_W-1:0];
      end else begin
        o_out_addr <= o_out_addr;
        o_out_data <= o_out_data;
      end
    end
  end

endmodule

// File: tb/tb_pix_align_delay.sv
// -----------------------------------------------------------------------------
// tb_pix_align_delay
//   Self-checking bench for pix_align_delay. Inputs of cycle c are driven just
//   after edge c and captured at edge c+1. A timeline model predicts the
//   outputs after every edge t: the sample driven in cycle t-D is shown if it
//   was valid, was driven no earlier than the last reset/delay change, and the
//   refill window has expired. in_data = cycle index, in_addr = index + 0x100.
// -----------------------------------------------------------------------------
module tb_pix_align_delay;
  localparam int DATA_W    = 36;
  localparam int ADDR_W    = 19;
  localparam int MAX_DELAY = 128;
  localparam int DSEL_W    = 8;
  localparam int HN        = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic [DSEL_W-1:0] delay_sel;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              cfg_busy;

  always #5 clk = ~clk;

  pix_align_delay #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DELAY(MAX_DELAY), .DSEL_W(DSEL_W)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_delay_sel(delay_sel),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_in_addr(in_addr),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_addr(out_addr),
    .o_cfg_busy(cfg_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;

  // input history, indexed by the cycle in which it was driven
  logic              h_v [HN];
  logic [DATA_W-1:0] h_d [HN];
  logic [ADDR_W-1:0] h_a [HN];
  // observed output history, indexed by edge
  logic              ov_hist [HN];
  logic [DATA_W-1:0] od_hist [HN];

  // model state
  logic              m_known = 1'b0;
  int                m_d, m_busy_left, m_epoch;
  logic              m_ov;
  logic [DATA_W-1:0] m_od;
  logic [ADDR_W-1:0] m_oa;

  int busy_cnt = 0;
  int first_ov = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @edge %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  function automatic int clamp(input int sel);
    if (sel == 0) return 1;
    if (sel > MAX_DELAY) return MAX_DELAY;
    return sel;
  endfunction

  task automatic model_edge(input logic r, input int sel, input int t);
    int dn;
    int s;
    dn = clamp(sel);
    if (r) begin
      m_known = 1'b1;
      m_d = dn; m_busy_left = 0; m_epoch = t;
      m_ov = 1'b0; m_od = '0; m_oa = '0;
    end else begin
      if (dn != m_d) begin
        m_d = dn; m_busy_left = dn; m_epoch = t;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end
      s = t - m_d;
      m_ov = 1'b0;
      if (m_busy_left == 0 && s >= m_epoch) begin
        if (h_v[s]) begin
          m_ov = 1'b1; m_od = h_d[s]; m_oa = h_a[s];
        end
      end
    end
  endtask

  task automatic drive(input logic v);
    in_valid = v;
    in_data  = DATA_W'(c);
    in_addr  = ADDR_W'(c + 256);
  endtask

  // one clock: record inputs, advance, update model, compare every output
  task automatic tick();
    logic r;
    int   sel;
    if (c >= HN - 2) begin
      $display("FAIL cycle_budget: got %0d expected < %0d", c, HN - 2);
      $fatal(1, "cycle budget exceeded");
    end
    h_v[c] = in_valid; h_d[c] = in_data; h_a[c] = in_addr;
    r = reset; sel = int'(delay_sel);
    @(posedge clk);
    #1;
    c++;
    model_edge(r, sel, c);
    if (m_known) begin
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("cfg_busy",  64'(cfg_busy),  64'(m_busy_left > 0));
      check("out_data",  64'(out_data),  64'(m_od));
      check("out_addr",  64'(out_addr),  64'(m_oa));
    end
    ov_hist[c] = out_valid;
    od_hist[c] = out_data;
    if (cfg_busy) busy_cnt++;
    if (first_ov < 0 && out_valid) first_ov = c;
  endtask

  initial begin
    int c_first, cs, p, nz;
    int pat [7];
    pat = '{1, 0, 1, 1, 0, 0, 1};

    reset = 1'b1; delay_sel = 8'd80; drive(1'b0);
    tick(); tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy",      64'(cfg_busy),  64'd0);
    check("reset_data",      64'(out_data),  64'd0);

    // stream at D=80 across several pointer wraps
    reset = 1'b0;
    c_first = c; first_ov = -1;
    for (int i = 0; i < 300; i++) begin drive(1'b1); tick(); end
    check("first_latency_80", 64'(first_ov - c_first), 64'd80);
    check("first_data_80",    64'(od_hist[first_ov]),  64'(c_first));

    // switch 80 -> 20
    cs = c; delay_sel = 8'd20; busy_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      drive(1'b1); tick();
      if (k == 21) begin
        check("refill_first_valid", 64'(out_valid), 64'd1);
        check("refill_first_data",  64'(out_data),  64'(cs + 1));
      end
    end
    check("busy_len_20", 64'(busy_cnt), 64'd20);

    // clamping: 1, 0 (same effective delay, no flush), 200 -> 128
    delay_sel = 8'd1;
    for (int i = 0; i < 5; i++) begin drive(1'b1); tick(); end
    check("lat_sel1", 64'(out_data), 64'(c - 1));
    delay_sel = 8'd0; busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin drive(1'b1); tick(); end
    check("lat_sel0", 64'(out_data), 64'(c - 1));
    check("sel0_no_flush", 64'(busy_cnt), 64'd0);
    delay_sel = 8'd200;
    for (int i = 0; i < 140; i++) begin drive(1'b1); tick(); end
    check("lat_sel200", 64'(out_data), 64'(c - 128));
    check("addr_sel200", 64'(out_addr), 64'(c - 128 + 256));

    // valid pattern at D=5
    delay_sel = 8'd5;
    for (int i = 0; i < 10; i++) begin drive(1'b1); tick(); end
    p = c;
    for (int k = 0; k < 7; k++) begin drive(pat[k][0]); tick(); end
    for (int i = 0; i < 12; i++) begin drive(1'b0); tick(); end
    for (int k = 0; k < 7; k++)
      check("pattern_valid", 64'(ov_hist[p + k + 5]), 64'(pat[k]));
    check("hold_data_gap1", 64'(od_hist[p + 6]),  64'(p));
    check("hold_data_gap2", 64'(od_hist[p + 10]), 64'(p + 3));

    // 80 -> 20, then 40 five cycles into the flush
    delay_sel = 8'd80;
    for (int i = 0; i < 100; i++) begin drive(1'b1); tick(); end
    delay_sel = 8'd20; busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin drive(1'b1); tick(); end
    delay_sel = 8'd40;
    for (int i = 0; i < 55; i++) begin drive(1'b1); tick(); end
    check("busy_len_restart", 64'(busy_cnt), 64'd45);
    check("lat_restart_40",   64'(out_data), 64'(c - 40));

    // reset mid-stream at D=80, then idle input
    delay_sel = 8'd80;
    for (int i = 0; i < 150; i++) begin drive(1'b1); tick(); end
    check("pre_reset_lat80", 64'(out_data), 64'(c - 80));
    reset = 1'b1; drive(1'b1); tick();
    reset = 1'b0; nz = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b0); tick();
      if (out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0) nz++;
    end
    check("post_reset_quiet", 64'(nz), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
